// File: rtl/sva_rtl_pkg.sv
// Shared types and helpers for the intersect scheduler.
// Slot state encoding and a saturating counter step.
package sva_rtl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_t;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/attempt_slot.sv
// One window tracker: samples hit over WIN cycles from its start
// and signals done with a verdict in the last sampled cycle.
module attempt_slot
    import sva_rtl_pkg::*;
#(
    parameter int WIN = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hit,
    output logic active,
    output logic done,
    output logic verdict
);

    localparam int CW = $clog2(WIN + 1);

    slot_state_t   state;
    logic [CW-1:0] cnt;
    logic          flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            flag  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // a one-cycle window completes without ever going active
                    if (start && WIN > 1) begin
                        state <= ACTIVE;
                        cnt   <= CW'(WIN - 1);
                        flag  <= hit;
                    end
                end
                ACTIVE: begin
                    flag <= flag | hit;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        flag  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        active  = (state == ACTIVE);
        done    = (active && cnt == CW'(1))
                || (!active && start && WIN == 1);
        verdict = active ? (flag | hit) : hit;
    end

endmodule

// File: rtl/intersect_sched.sv
// Multi-slot window scheduler: allocates attempts to free slots,
// reports match/fail/overflow pulses and saturating statistics.
module intersect_sched
    import sva_rtl_pkg::*;
#(
    parameter int WIN     = 5,
    parameter int N_SLOTS = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             signal_1,
    input  logic             signal_2,
    output logic             match,
    output logic             fail,
    output logic             overflow,
    output logic             busy,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [N_SLOTS-1:0] act;
    logic [N_SLOTS-1:0] grant;
    logic [N_SLOTS-1:0] done;
    logic [N_SLOTS-1:0] verd;
    logic               hit;
    logic               full;
    logic               found;
    logic               any_match;
    logic               any_fail;
    logic               drop;

    assign hit  = signal_1 & signal_2;
    assign full = &act;

    // lowest-index free slot, judged on registered state
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!act[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        attempt_slot #(
            .WIN (WIN)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .start   (en & grant[g]),
            .hit     (hit),
            .active  (act[g]),
            .done    (done[g]),
            .verdict (verd[g])
        );
    end

    assign any_match = |(done & verd);
    assign any_fail  = |(done & ~verd);
    assign drop      = en & full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match     <= 1'b0;
            fail      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            match_cnt <= '0;
            fail_cnt  <= '0;
            drop_cnt  <= '0;
        end else begin
            match    <= any_match;
            fail     <= any_fail;
            overflow <= drop;
            // stays high through the verdict cycle of the last attempt
            busy     <= (|act) | (en & ~full);
            if (any_match)
                match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CNT_W));
            if (any_fail)
                fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), CNT_W));
            if (drop)
                drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
        end
    end

endmodule

// File: tb/tb_intersect_sched.sv
// Directed vector bench for intersect_sched plus small-parameter variants.
module tb_intersect_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;

    logic        m, f, o, b;
    logic [15:0] mc, fc, dc;
    logic        m_s, f_s, o_s, b_s;
    logic [1:0]  mc_s, fc_s, dc_s;
    logic        m_w, f_w, o_w, b_w;
    logic [15:0] mc_w, fc_w, dc_w;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    intersect_sched #(.WIN(5), .N_SLOTS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .signal_1(s1), .signal_2(s2),
        .match(m), .fail(f), .overflow(o), .busy(b),
        .match_cnt(mc), .fail_cnt(fc), .drop_cnt(dc)
    );

    intersect_sched #(.WIN(5), .N_SLOTS(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en),
        .signal_1(s1), .signal_2(s2),
        .match(m_s), .fail(f_s), .overflow(o_s), .busy(b_s),
        .match_cnt(mc_s), .fail_cnt(fc_s), .drop_cnt(dc_s)
    );

    intersect_sched #(.WIN(1), .N_SLOTS(1), .CNT_W(16)) dut_w (
        .clk(clk), .rst(rst), .en(en),
        .signal_1(s1), .signal_2(s2),
        .match(m_w), .fail(f_w), .overflow(o_w), .busy(b_w),
        .match_cnt(mc_w), .fail_cnt(fc_w), .drop_cnt(dc_w)
    );

    typedef struct {
        logic        r, e, a, c;
        logic        m, f, o, b;
        logic [15:0] mc, fc, dc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, e, a, c, xm, xf, xo, xb,
                       input int xmc, xfc, xdc);
        vec_t v;
        v.r = r; v.e = e; v.a = a; v.c = c;
        v.m = xm; v.f = xf; v.o = xo; v.b = xb;
        v.mc = 16'(xmc); v.fc = 16'(xfc); v.dc = 16'(xdc);
        vq.push_back(v);
    endtask

    task automatic tick(input logic r, e, a, c);
        @(posedge clk);
        #1;
        rst = r; en = e; s1 = a; s2 = c;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic ovf_w_seen;

    initial begin
        // match after single hit
        add(0,1,0,0, 0,0,0,0, 0,0,0);
        add(0,0,1,0, 0,0,0,1, 0,0,0);
        add(0,0,1,1, 0,0,0,1, 0,0,0);
        add(0,0,0,0, 0,0,0,1, 0,0,0);
        add(0,0,0,1, 0,0,0,1, 0,0,0);
        add(0,0,0,0, 1,0,0,1, 1,0,0);
        add(0,0,0,0, 0,0,0,0, 1,0,0);
        // no hit -> fail
        add(0,1,0,0, 0,0,0,0, 1,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0,0, 0,0,0,1, 1,0,0);
        add(0,0,0,0, 0,1,0,1, 1,1,0);
        add(0,0,0,0, 0,0,0,0, 1,1,0);
        // overlapping starts, one hit
        add(0,1,0,0, 0,0,0,0, 1,1,0);
        add(0,1,1,1, 0,0,0,1, 1,1,0);
        add(0,1,0,0, 0,0,0,1, 1,1,0);
        add(0,1,0,0, 0,0,0,1, 1,1,0);
        add(0,0,0,0, 0,0,0,1, 1,1,0);
        add(0,0,0,0, 1,0,0,1, 2,1,0);
        add(0,0,0,0, 1,0,0,1, 3,1,0);
        add(0,0,0,0, 0,1,0,1, 3,2,0);
        add(0,0,0,0, 0,1,0,1, 3,3,0);
        add(0,0,0,0, 0,0,0,0, 3,3,0);
        // en held: overflow then slot reuse
        add(0,1,0,0, 0,0,0,0, 3,3,0);
        for (int i = 0; i < 4; i++) add(0,1,0,0, 0,0,0,1, 3,3,0);
        add(0,1,0,0, 0,1,1,1, 3,4,1);
        add(0,0,0,0, 0,1,0,1, 3,5,1);
        add(0,0,0,0, 0,1,0,1, 3,6,1);
        add(0,0,0,0, 0,1,0,1, 3,7,1);
        add(0,0,0,0, 0,0,0,1, 3,7,1);
        add(0,0,0,0, 0,1,0,1, 3,8,1);
        add(0,0,0,0, 0,0,0,0, 3,8,1);
        // reset mid-attempt, then first start after release
        add(0,1,0,0, 0,0,0,0, 3,8,1);
        add(0,0,1,1, 0,0,0,1, 3,8,1);
        add(0,0,0,0, 0,0,0,1, 3,8,1);
        add(1,0,0,0, 0,0,0,0, 0,0,0);
        add(0,1,1,1, 0,0,0,0, 0,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0,0, 0,0,0,1, 0,0,0);
        add(0,0,0,0, 1,0,0,1, 1,0,0);
        add(0,0,0,0, 0,0,0,0, 1,0,0);

        @(negedge clk);
        chk("reset_state", {m, f, o, b, mc, fc, dc}, '0);
        tick(1, 0, 0, 0);

        foreach (vq[k]) begin
            tick(vq[k].r, vq[k].e, vq[k].a, vq[k].c);
            chk($sformatf("vec%0d", k),
                {m, f, o, b, mc, fc, dc},
                {vq[k].m, vq[k].f, vq[k].o, vq[k].b,
                 vq[k].mc, vq[k].fc, vq[k].dc});
        end

        // saturation (CNT_W=2) and WIN=1 behaviour on the same stimulus
        tick(1, 0, 0, 0);
        ovf_w_seen = 1'b0;
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        chk("w1_fail_next", {m_w, f_w}, 2'b01);
        chk("w1_busy", 1'(b_w), 1'b1);
        ovf_w_seen |= o_w;
        tick(0, 1, 0, 0); ovf_w_seen |= o_w;
        tick(0, 1, 0, 0); ovf_w_seen |= o_w;
        tick(0, 0, 0, 0); ovf_w_seen |= o_w;
        tick(0, 1, 0, 0); ovf_w_seen |= o_w;
        for (int i = 6; i <= 8; i++) begin
            tick(0, 0, 0, 0);
            ovf_w_seen |= o_w;
        end
        chk("sat_fail_c8", 2'(fc_s), 2'd3);
        for (int i = 9; i <= 11; i++) begin
            tick(0, 0, 0, 0);
            ovf_w_seen |= o_w;
        end
        chk("sat_fail_end", 2'(fc_s), 2'd3);
        chk("sat_other", {mc_s, dc_s}, 4'd0);
        chk("w1_fail_cnt", 16'(fc_w), 16'd5);
        chk("w1_no_ovf", 1'(ovf_w_seen), 1'b0);

        // WIN=1 back-to-back reuse
        tick(0, 1, 1, 1);
        tick(0, 1, 0, 0);
        chk("w1_match", {m_w, f_w}, 2'b10);
        tick(0, 0, 0, 0);
        chk("w1_fail_b2b", {m_w, f_w}, 2'b01);
        chk("w1_cnts", {mc_w, fc_w}, {16'd1, 16'd6});

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
